// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter wide enough to hold WIDTH-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 32'($clog2(w)) + 32'd1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb;

    assign axb  = a ^ b;
    assign d    = axb ^ bin;
    assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept_c;
    logic             last_c;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d_c;
    logic             bout_c;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (borrow),
        .d    (d_c),
        .bout (bout_c)
    );

    assign bout = borrow;

    // Next-state decode; accept and last-bit strobes come from the current state.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with handshake/status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ST_IDLE);
            out_valid <= (state_next == ST_DONE);
            busy      <= (state_next == ST_RUN);
        end
    end

    // Serial datapath; diff doubles as the result shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept_c) begin
            sa     <= a;
            sb     <= b;
            diff   <= '0;
            borrow <= bin;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            ovf    <= 1'b0;
`endif
        end else if (state == ST_RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            diff   <= {d_c, diff[WIDTH-1:1]};
            borrow <= bout_c;
            cnt    <= cnt + CW'(1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // The final serial bit is the result MSB.
            if (last_c) begin
                ovf <= (a_msb ^ b_msb) & (a_msb ^ d_c);
            end
`endif
        end
    end

endmodule
